alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_rsp_fifo.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: pipe latency, opcodes and
// the response-buffer entry layout.
package alu_issue_pkg;

    localparam int ALU_LATENCY = 3;

    localparam logic [7:0] OP_ADD = 8'h2C;
    localparam logic [7:0] OP_SUB = 8'hAC;

    // Entry field widths; the controller's DATA_WIDTH/TAG_WIDTH default to these.
    localparam int RSP_DATA_W = 16;
    localparam int RSP_TAG_W  = 3;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic                  cout;
        logic [RSP_TAG_W-1:0]  tag;
    } rsp_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head entry is visible whenever valid_o is high,
// and a push is accepted while full if a pop happens in the same cycle.
module alu_rsp_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  rsp_entry_t push_data_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic       valid_o,
    output logic       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rsp_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers are PW bits wide, so a power-of-two depth wraps for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a fixed 3-stage ALU pipe with a buffered response port.
// Define ALU_ISSUE_PERF_CNT_EN to add the perf_issued/perf_stall counters.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = RSP_DATA_W,
    parameter int TAG_WIDTH  = RSP_TAG_W,
    parameter int RSP_DEPTH  = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [7:0]            req_ctrl,
    input  logic                  req_cin,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_out,
    output logic                  rsp_cout,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [7:0]            alu_ctrl,
    output logic                  alu_cin,
    output logic                  alu_pipe_active,
    output logic                  alu_out_en,
    output logic                  alu_reset_n,
    input  logic [DATA_WIDTH-1:0] alu_out,
`ifdef ALU_ISSUE_PERF_CNT_EN
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall,
`endif
    input  logic                  alu_cout
);

    localparam int LAST = ALU_LATENCY - 1;

    logic [ALU_LATENCY-1:0] v_q, v_d;
    logic [TAG_WIDTH-1:0]   t_q [ALU_LATENCY];
    logic [TAG_WIDTH-1:0]   t_d [ALU_LATENCY];
    logic                   stall, pop, push, xfer;
    logic                   fifo_full, fifo_valid;
    rsp_entry_t             push_entry, head_entry;

    assign pop   = fifo_valid & rsp_ready;
    // Only stall when the oldest op is valid and has nowhere to go this cycle.
    assign stall = v_q[LAST] & fifo_full & ~pop;

    assign alu_pipe_active = ~stall;
    assign req_ready       = ~stall;
    assign xfer            = req_valid & req_ready;
    assign alu_out_en      = v_q[LAST];
    assign alu_reset_n     = ~reset;

    assign alu_a    = req_valid ? req_a    : '0;
    assign alu_b    = req_valid ? req_b    : '0;
    assign alu_ctrl = req_valid ? req_ctrl : 8'h00;
    assign alu_cin  = req_valid & req_cin;

    assign v_d[0] = alu_pipe_active ? xfer    : v_q[0];
    assign t_d[0] = alu_pipe_active ? req_tag : t_q[0];

    generate
        for (genvar gi = 1; gi < ALU_LATENCY; gi++) begin : g_shift
            assign v_d[gi] = alu_pipe_active ? v_q[gi-1] : v_q[gi];
            assign t_d[gi] = alu_pipe_active ? t_q[gi-1] : t_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                t_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            t_q <= t_d;
        end
    end

    assign push       = v_q[LAST] & alu_pipe_active;
    assign push_entry = '{data: alu_out, cout: alu_cout, tag: t_q[LAST]};

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_out   = head_entry.data;
    assign rsp_cout  = head_entry.cout;
    assign rsp_tag   = head_entry.tag;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (xfer) begin
                perf_issued_q <= sat_inc32(perf_issued_q);
            end
            if (stall) begin
                perf_stall_q <= sat_inc32(perf_stall_q);
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: attaches a 3-stage ALU pipe and checks responses
// against an in-order queue of results computed from each accepted request.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    localparam int DW = 16;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [DW-1:0] req_a, req_b;
    logic [7:0]    req_ctrl;
    logic          req_cin;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_out;
    logic          rsp_cout;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [7:0]    alu_ctrl;
    logic          alu_cin, alu_pipe_active, alu_out_en, alu_reset_n, alu_cout;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0]   perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RSP_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_ctrl        (req_ctrl),
        .req_cin         (req_cin),
        .req_tag         (req_tag),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_out         (rsp_out),
        .rsp_cout        (rsp_cout),
        .rsp_tag         (rsp_tag),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctrl        (alu_ctrl),
        .alu_cin         (alu_cin),
        .alu_pipe_active (alu_pipe_active),
        .alu_out_en      (alu_out_en),
        .alu_reset_n     (alu_reset_n),
        .alu_out         (alu_out),
`ifdef ALU_ISSUE_PERF_CNT_EN
        .perf_issued     (perf_issued),
        .perf_stall      (perf_stall),
`endif
        .alu_cout        (alu_cout)
    );

    // Arithmetic the attached ALU performs: {cout, out}.
    function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [7:0] op, input logic cin);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            OP_SUB:  return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // The attached 3-stage ALU pipe.
    logic [DW:0] st_q [3];
    always @(posedge clk) begin
        if (!alu_reset_n) begin
            st_q[0] <= '0;
            st_q[1] <= '0;
            st_q[2] <= '0;
        end else if (alu_pipe_active) begin
            st_q[0] <= alu_fn(alu_a, alu_b, alu_ctrl, alu_cin);
            st_q[1] <= st_q[0];
            st_q[2] <= st_q[1];
        end
    end
    assign alu_out  = st_q[2][DW-1:0];
    assign alu_cout = st_q[2][DW];

    typedef struct {
        logic [DW-1:0] d;
        logic          c;
        logic [TW-1:0] t;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;
    int          n_rsp  = 0;
    logic [7:0]  ops [3] = '{OP_ADD, OP_SUB, 8'h3C};

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
            $error("check %s", name);
        end
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next edge.
    task automatic tick();
        exp_t  e;
        logic [DW:0] r;
        @(negedge clk);
        if (req_valid && req_ready) begin
            r = alu_fn(req_a, req_b, req_ctrl, req_cin);
            e.d = r[DW-1:0];
            e.c = r[DW];
            e.t = req_tag;
            q.push_back(e);
            n_xfer++;
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("rsp_extra", 32'(rsp_valid), 32'(0));
            end else begin
                e = q.pop_front();
                check("rsp_out", 32'(rsp_out), 32'(e.d));
                check("rsp_cout", 32'(rsp_cout), 32'(e.c));
                check("rsp_tag", 32'(rsp_tag), 32'(e.t));
                n_rsp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int k);
        req_a    = DW'($urandom);
        req_b    = DW'($urandom);
        req_ctrl = ops[$urandom_range(0, 2)];
        req_cin  = 1'($urandom);
        req_tag  = TW'(k);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check("drain_empty", 32'(q.size()), 32'(0));
    endtask

    task automatic single_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag,
                             input logic [DW-1:0] exp_out, input logic exp_cout);
        int lat;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a = a; req_b = b; req_ctrl = OP_ADD; req_cin = 1'b0; req_tag = tag;
        #1;
        check("single_req_ready", 32'(req_ready), 32'(1));
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("single_latency", 32'(lat), 32'(4));
        check("single_out", 32'(rsp_out), 32'(exp_out));
        check("single_cout", 32'(rsp_cout), 32'(exp_cout));
        check("single_tag", 32'(rsp_tag), 32'(tag));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int start;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_ctrl = '0; req_cin = 1'b0; req_tag = '0;
        @(posedge clk); #1;
        tick();
        check("reset_alu_reset_n", 32'(alu_reset_n), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_req_ready", 32'(req_ready), 32'(1));
        reset = 1'b0;
        #1;
        check("run_alu_reset_n", 32'(alu_reset_n), 32'(1));
        check("idle_out_en", 32'(alu_out_en), 32'(0));

        // Directed single operations, including carry-out wrap.
        single_op(16'h0001, 16'h0002, 3'd5, 16'h0003, 1'b0);
        single_op(16'hFFFF, 16'h0001, 3'd2, 16'h0000, 1'b1);

        // Eight back-to-back with the response side blocked.
        rsp_ready = 1'b0;
        base = n_xfer;
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1;
            drive_rand(k);
            start = n_xfer;
            for (int i = 0; i < 6 && n_xfer == start; i++) tick();
        end
        check("bp_transfers", 32'(n_xfer - base), 32'(7));
        check("bp_req_ready", 32'(req_ready), 32'(0));
        check("bp_out_en", 32'(alu_out_en), 32'(1));
        check("bp_buffered", 32'(dut.u_fifo.count_q), 32'(4));
        check("bp_head_tag", 32'(rsp_tag), 32'(0));
        rsp_ready = 1'b1;
        base = n_rsp;
        for (int i = 0; i < 30 && !(q.size() == 0 && !req_valid); i++) begin
            tick();
            if (n_xfer - (n_rsp - base) >= 0 && req_valid && q.size() != 0 && rsp_tag == 3'd0) req_valid = 1'b1;
            if (q.size() != 0 && q[q.size()-1].t == 3'd7) req_valid = 1'b0;
        end
        check("bp_all_returned", 32'(n_rsp - base), 32'(8));

        // Full buffer drained one per cycle while requests keep coming.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 12 && req_ready; i++) begin
            drive_rand(i);
            tick();
        end
        check("fill_stall", 32'(req_ready), 32'(0));
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_rand(i);
            #1;
            check("stream_req_ready", 32'(req_ready), 32'(1));
            check("stream_rsp_valid", 32'(rsp_valid), 32'(1));
            tick();
        end
        drain();

        // Reset with three ops in flight and two buffered.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand(i);
            tick();
        end
        req_valid = 1'b0;
        check("mid_buffered", 32'(dut.u_fifo.count_q), 32'(2));
        check("mid_in_flight", 32'(alu_out_en), 32'(1));
        reset = 1'b1;
        tick();
        q.delete();
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_req_ready", 32'(req_ready), 32'(1));
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_no_stale", 32'(rsp_valid), 32'(0));
        end

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            drive_rand(i);
            tick();
        end
        drain();

`ifdef ALU_ISSUE_PERF_CNT_EN
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        reset = 1'b0;
        q.delete();
        check("perf_issued_reset", perf_issued, 32'd0);
        check("perf_stall_reset", perf_stall, 32'd0);
        req_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_rand(i);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(i);
            tick();
        end
        drain();
        check("perf_issued", perf_issued, 32'd10);
        check("perf_stall", perf_stall, 32'd6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
